// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 round-robin stream mux family:
// default sizing, the packet-lock state type and the wrap-around index helper.
package mux_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } lock_state_t;

  // Successor of idx in a ring of n entries (n-1 wraps to 0, any n >= 2).
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_nx1_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping modulo N_CH) wins. Works for any N_CH >= 2, power of two or not.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any_req
);

  int   idx;
  logic hit;

  // Walk the ring starting at ptr; idx visits every channel exactly once,
  // so each grant bit is written exactly once per evaluation.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    hit       = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx        = int'(ptr) + k;
      idx        = (idx >= N_CH) ? idx - N_CH : idx;
      hit        = !any_req && req[idx];
      grant[idx] = hit;
      grant_idx  = hit ? SEL_W'(idx) : grant_idx;
      any_req    = any_req | req[idx];
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-channel valid/ready stream mux with round-robin arbitration and a single
// registered output stage. Optional packet locking (whole packets from one
// channel, delimited by in_last) is enabled with the macro MUX_PKT_LOCK_EN.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [N_CH-1:0]       in_last,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_last
);

  logic             load;
  logic             xfer;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] ptr;
  logic             any_req;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  // Output register can accept a beat when empty or when drained this cycle.
  assign load = !out_valid || out_ready;
  assign xfer = load && any_req;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Route the granted channel's data to the output register input.
  always_comb begin
    sel_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];
  end

  // Ready goes only to the winner, only when the output can load; forced low
  // while rst is high so producers see no handshake during reset.
  always_comb begin
    in_ready = (rst || !load) ? '0 : grant;
  end

`ifdef MUX_PKT_LOCK_EN
  lock_state_t      state;
  lock_state_t      state_nxt;
  logic [SEL_W-1:0] lock_ch;
  logic [SEL_W-1:0] lock_nxt;

  assign sel_last = in_last[grant_idx];

  // Inside a packet only the locked channel may compete.
  always_comb begin
    req = '0;
    if (state == LOCK) begin
      req[lock_ch] = in_valid[lock_ch];
    end else begin
      req = in_valid;
    end
  end

  // Packet-lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_nxt;
    end
  end

  // Enter LOCK on a non-final beat, leave on the final beat of the packet.
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_ch;
    case (state)
      ARB: begin
        if (xfer && !sel_last) begin
          state_nxt = LOCK;
          lock_nxt  = grant_idx;
        end else begin
          state_nxt = ARB;
        end
      end
      LOCK: begin
        if (xfer && sel_last) begin
          state_nxt = ARB;
        end else begin
          state_nxt = LOCK;
        end
      end
      default: begin
        state_nxt = ARB;
        lock_nxt  = '0;
      end
    endcase
  end
`else
  logic unused_last;

  assign req         = in_valid;
  assign sel_last    = 1'b0;
  assign unused_last = ^in_last;
`endif

  // Output stage and priority pointer. The pointer moves past the winner on
  // every transfer; in LOCK the winner is lock_ch, so the packet's final beat
  // leaves ptr at lock_ch+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
      out_last  <= sel_last;
      ptr       <= SEL_W'(next_idx(int'(grant_idx), N_CH));
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
- Parametrised N-channel successor to the team's 2:1 mux.
- Each input channel is a valid/ready stream.
- A round-robin arbiter picks one requesting channel per beat and drives its data through a single registered output stage.
- Sits between multiple producers (e.g. per-lane data sources) and one shared consumer.

Parameters:
N_CH, 4, number of input channels; legal range ≥2.
WIDTH, 8, data width per channel in bits.
SEL_W, $clog2(N_CH), derived width of the channel index; not to be overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-high.
in_data  input  N_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
in_valid  input  N_CH  per-channel valid.
in_ready  output  N_CH  per-channel ready; one-hot or zero.
in_last  input  N_CH  per-channel end-of-packet marker; used only when the optional feature is enabled.
out_data  output  WIDTH  registered selected data.
out_valid  output  1  registered output valid.
out_ready  input  1  consumer ready.
out_sel  output  SEL_W  index of the channel that supplied out_data.
out_last  output  1  registered in_last of the supplied beat; driven 0 when the feature is disabled.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, priority pointer ptr=0, state=ARB.
- Load enable: load = !out_valid || out_ready (output register empty or being drained this cycle).
- Arbitration (combinational): search channels ptr, ptr+1, …, N_CH-1, 0, …, ptr-1 (wrap modulo N_CH). The first channel with in_valid=1 wins, index g.
- in_ready[g] = load; all other in_ready bits = 0. in_ready must not depend on out_valid of another cycle except through load.
- Transfer: on a clock edge with load=1 and any in_valid=1:
  - out_data <= channel g data; out_sel <= g; out_valid <= 1.
  - ptr <= (g+1) mod N_CH. Wrap from N_CH-1 to 0 is required; non-power-of-2 N_CH must wrap correctly.
- Drain with no new request: on a clock edge with load=1, no in_valid, and out_ready=1 → out_valid <= 0. ptr and the output data registers hold.
- Stall: while out_valid=1 and out_ready=0, out_data, out_sel and out_last are held stable and all in_ready are 0.
- Latency and throughput: input handshake to out_valid is 1 cycle. Sustained throughput is 1 beat/cycle with out_ready held high.
- Simultaneous drain and load in the same cycle: new beat replaces old with no bubble.
- Fairness: every continuously-valid channel is served within N_CH output beats.
- No combinational path from in_valid to out_valid. Combinational path out_ready → in_ready is permitted.
- Reset mid-operation: a beat in the output register is discarded. in_ready falls to 0 asynchronously with rst, and stays 0 until after rst deasserts.

Optional Feature:
- Macro: MUX_PKT_LOCK_EN.
- Defined:
  - Two-state FSM, ARB/LOCK.
  - ARB: arbitrate as above. A transfer with in_last[g]=0 moves to LOCK and stores lock_ch=g. A transfer with in_last[g]=1 stays in ARB.
  - LOCK: only lock_ch may be granted; other channels' in_ready=0 even if valid. The transfer with in_last[lock_ch]=1 returns to ARB and sets ptr <= lock_ch+1.
  - out_last tracks the transferred in_last.
- Undefined:
  - No FSM; in_last is ignored, out_last is tied 0.
  - Every beat arbitrates independently.

Decomposition:
- Package mux_pkg:
  - Default N_CH and WIDTH constants.
  - lock_state_t enum {ARB, LOCK}.
  - Function next_idx(idx, n), giving the wrap-around increment.
- Sub-module rr_arbiter:
  - Parameter N_CH.
  - Inputs req[N_CH], ptr[SEL_W].
  - Outputs grant one-hot[N_CH], grant_idx[SEL_W], any_req.
  - Purely combinational; reusable by other arbitrated blocks.
- The top level holds ptr, the FSM, and the output register.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 → out_valid, out_sel and in_ready read 0 immediately; after release the first grant goes to ch0.
- Round-robin: N_CH=4, all in_valid=1, data ch i=8'hA0+i, out_ready=1 → out_data sequence A0,A1,A2,A3,A0 on consecutive cycles; out_sel 0,1,2,3,0.
- Backpressure: out_ready=0 for 3 cycles with ch2 data 8'h5C captured → out_data stays 5C, in_ready=0; on release the next beat appears with no gap and no loss.
- Sparse/wrap: only ch3 and ch1 valid, ptr=2 → ch3 served first, then ch1; N_CH=3 wrap from 2 → 0 checked.
- Idle drain: single beat from ch0, then no valid, out_ready=1 → out_valid is 1 for exactly one cycle, then 0.
- With MUX_PKT_LOCK_EN: ch1 sends a 3-beat packet (last on beat 3) while ch0/ch2 stay valid → three consecutive ch1 beats with out_last=0,0,1, then ch2 is granted.
